alu_logic_sequencer: RTL and testbench
======================================

# alu_logic_sequencer

Sequential command front-end for the ALU logic unit. It accepts one logic command at a time over a valid/ready handshake, registers the operands and opcode, and drives the logic unit's operand, select and active-low enable inputs. It then captures the logic unit's combinational result and returns it over a second valid/ready handshake. It sits between the ALU control path and the combinational logic unit; results can be chained back as operand A.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk_in  input  1  clock; all state changes on rising edge
- rst_in  input  1  synchronous, active-high reset
- cmd_valid_in  input  1  command present
- cmd_ready_out  output  1  sequencer can accept a command
- cmd_op_in  input  3  logic opcode
- cmd_a_in  input  WIDTH  operand A (ignored when chaining)
- cmd_b_in  input  WIDTH  operand B
- cmd_chain_in  input  1  use last result as operand A
- lu_a_out  output  WIDTH  operand A to logic unit
- lu_b_out  output  WIDTH  operand B to logic unit
- lu_s_out  output  3  select to logic unit
- lu_en_out  output  1  logic unit enable, active low
- lu_y_in  input  WIDTH  logic unit result
- res_valid_out  output  1  result present
- res_ready_in  input  1  consumer takes result
- res_y_out  output  WIDTH  captured result
- res_err_out  output  1  command used a reserved opcode
- ops_count_out  output  CNT_W  completed result handshakes, wraps

## Operation
- Opcodes: 000 NAND, 001 NOR, 010 XOR, 101 AND, 110 OR, 111 NOT(A). 011 and 100 are reserved.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: cmd_ready_out=1. When cmd_valid_in=1, the command is accepted. The sequencer latches op and B. It latches A as last_res when cmd_chain_in=1, else as cmd_a_in. It then moves to ISSUE.
  - ISSUE: operand and select outputs are driven from the latched registers. lu_en_out=0 unless the opcode is reserved. At the clock edge, res_y_out is loaded with lu_y_in, or with 0 for a reserved opcode. res_err_out is set for a reserved opcode. last_res is loaded with the same value. The FSM moves to HOLD.
  - HOLD: res_valid_out=1. res_y_out and res_err_out are held stable. When res_ready_in=1, ops_count_out increments and the FSM moves to IDLE.
- lu_en_out=1 in every state except ISSUE with a non-reserved opcode.
- lu_a_out, lu_b_out and lu_s_out hold their last latched values outside ISSUE.
- Reserved opcode: a response is still produced, with res_y_out=0 and res_err_out=1. last_res becomes 0.
- ops_count_out wraps from 2^CNT_W-1 to 0. Error responses are counted.
- cmd_ready_out=0 in ISSUE and HOLD. Commands presented there are not accepted and must be held by the source.
- Reset (any state, including mid-ISSUE or HOLD), next cycle:
  - state IDLE
  - cmd_ready_out=1, res_valid_out=0, res_err_out=0
  - res_y_out=0, last_res=0, ops_count_out=0
  - lu_en_out=1, lu_a_out=0, lu_b_out=0, lu_s_out=0
  - An in-flight command is dropped without a response.

## Timing
- Accept at edge T, i.e. cmd_valid_in & cmd_ready_out sampled high.
- Cycle T+1: ISSUE, lu_en_out low.
- Cycle T+2: res_valid_out high.
- Minimum command-to-command spacing is 3 cycles. This requires res_ready_in=1 on the first HOLD cycle.
- lu_y_in is sampled only at the end of ISSUE. The logic unit must settle within one cycle.
- Result handshake at edge H: ops_count_out updates after H and the FSM is in IDLE. cmd_ready_out rises the cycle after H; there is no same-cycle turnaround.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: OP_NAND, OP_NOR, OP_XOR, OP_AND, OP_OR, OP_NOT
  - an is_reserved function for opcodes 011 and 100
  - the FSM state encoding
- No sub-module. The logic unit is instantiated beside this block at ALU top level, and the bench connects the two.

## Test plan
- NAND, a=F0, b=3C, op 000:
  - cycle T+1: lu_en_out=0, lu_s_out=000, lu_a_out=F0, lu_b_out=3C
  - cycle T+2: res_y_out=CF, res_err_out=0
- Chaining:
  - XOR A5,FF gives 5A.
  - Then op 101 with cmd_chain_in=1, b=0F, cmd_a_in=77: lu_a_out=5A, res_y_out=0A.
- Reserved op 011, a=FF, b=FF: lu_en_out stays 1 throughout, res_y_out=00, res_err_out=1, ops_count_out increments.
- Backpressure, res_ready_in low 5 cycles in HOLD:
  - result held stable, cmd_ready_out=0, count unchanged
  - on release, count +1 and cmd_ready_out=1 the next cycle
- rst_in pulsed during ISSUE of OR 12,34:
  - next cycle all outputs at reset values, no response emitted
  - a following chained AND with b=FF yields 00
- CNT_W=2: four completed ops return ops_count_out to 0. Op 111 with a=00 returns the logic unit value 01.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Opcodes, reserved-opcode test and sequencer state encoding shared
//           by the ALU command path.
// Revision: 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_logic_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_logic_sequencer
// Purpose : Valid/ready command front-end that issues one operation to the
//           combinational logic unit and returns its captured result.
// Revision: 1.0  initial release
// ============================================================================
module alu_logic_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [2:0]       cmd_op_in,
  input  logic [WIDTH-1:0] cmd_a_in,
  input  logic [WIDTH-1:0] cmd_b_in,
  input  logic             cmd_chain_in,
  output logic [WIDTH-1:0] lu_a_out,
  output logic [WIDTH-1:0] lu_b_out,
  output logic [2:0]       lu_s_out,
  output logic             lu_en_out,
  input  logic [WIDTH-1:0] lu_y_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [WIDTH-1:0] res_y_out,
  output logic             res_err_out,
  output logic [CNT_W-1:0] ops_count_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  // The result register doubles as the chaining source (last result).
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             en_q, en_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    en_d    = en_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in) begin
          a_d     = cmd_chain_in ? y_q : cmd_a_in;
          b_d     = cmd_b_in;
          op_d    = cmd_op_in;
          ready_d = 1'b0;
          en_d    = is_reserved(cmd_op_in);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        y_d     = is_reserved(op_q) ? '0 : lu_y_in;
        err_d   = is_reserved(op_q);
        en_d    = 1'b1;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        en_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      en_q    <= en_d;
    end
  end

  assign cmd_ready_out = ready_q;
  assign lu_a_out      = a_q;
  assign lu_b_out      = b_q;
  assign lu_s_out      = op_q;
  assign lu_en_out     = en_q;
  assign res_valid_out = valid_q;
  assign res_y_out     = y_q;
  assign res_err_out   = err_q;
  assign ops_count_out = cnt_q;

endmodule : alu_logic_sequencer
`default_nettype wire

// File: tb/tb_alu_logic_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_logic_sequencer
// Purpose : Scoreboard bench for the sequencer paired with a logic unit model.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_logic_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  // Main instance
  logic        cmd_valid_in = 1'b0, cmd_chain_in = 1'b0, res_ready_in = 1'b1;
  logic [2:0]  cmd_op_in = '0;
  logic [7:0]  cmd_a_in = '0, cmd_b_in = '0;
  logic        cmd_ready_out, lu_en_out, res_valid_out, res_err_out;
  logic [7:0]  lu_a_out, lu_b_out, lu_y_in, res_y_out;
  logic [2:0]  lu_s_out;
  logic [15:0] ops_count_out;

  // Narrow instance for counter wrap
  logic        v2 = 1'b0, ch2 = 1'b0, rr2 = 1'b1;
  logic [2:0]  op2 = '0;
  logic [0:0]  a2 = '0, b2 = '0;
  logic        rdy2, en2, val2, err2;
  logic [0:0]  la2, lb2, ly2, y2;
  logic [2:0]  ls2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb_q[$];
  logic [7:0] last_res = '0;
  int         exp_cnt = 0;

  function automatic logic [7:0] lu_model(input logic en_n, input logic [2:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
    if (en_n) return 8'hC3;
    case (op)
      3'b000:  return ~(a & b);
      3'b001:  return ~(a | b);
      3'b010:  return a ^ b;
      3'b101:  return a & b;
      3'b110:  return a | b;
      3'b111:  return ~a;
      default: return 8'h96;
    endcase
  endfunction

  logic [7:0] ly2_full;
  always_comb lu_y_in  = lu_model(lu_en_out, lu_s_out, lu_a_out, lu_b_out);
  always_comb ly2_full = lu_model(en2, ls2, {7'd0, la2}, {7'd0, lb2});
  assign ly2 = ly2_full[0:0];

  alu_logic_sequencer #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op_in), .cmd_a_in(cmd_a_in),
    .cmd_b_in(cmd_b_in), .cmd_chain_in(cmd_chain_in), .lu_a_out(lu_a_out),
    .lu_b_out(lu_b_out), .lu_s_out(lu_s_out), .lu_en_out(lu_en_out),
    .lu_y_in(lu_y_in), .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_y_out(res_y_out), .res_err_out(res_err_out), .ops_count_out(ops_count_out)
  );

  alu_logic_sequencer #(.WIDTH(1), .CNT_W(2)) u_dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .cmd_valid_in(v2),
    .cmd_ready_out(rdy2), .cmd_op_in(op2), .cmd_a_in(a2),
    .cmd_b_in(b2), .cmd_chain_in(ch2), .lu_a_out(la2),
    .lu_b_out(lb2), .lu_s_out(ls2), .lu_en_out(en2),
    .lu_y_in(ly2), .res_valid_out(val2), .res_ready_in(rr2),
    .res_y_out(y2), .res_err_out(err2), .ops_count_out(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every result handshake pops one expected {err, y}.
  always @(negedge clk_in) begin
    if (!rst_in && res_valid_out && res_ready_in) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        check("res_y", res_y_out, e[7:0]);
        check("res_err", res_err_out, e[8]);
        check("lu_en_hold", lu_en_out, 1);
        check("ops_count", ops_count_out, exp_cnt);
        exp_cnt++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic chain, input bit push);
    logic [7:0] ea, ey;
    logic       rsv;
    int         n;
    n = 0;
    while (!cmd_ready_out && n < 50) begin
      @(posedge clk_in); #1; n++;
    end
    if (!cmd_ready_out) check("ready_timeout", 0, 1);
    rsv = (op == 3'b011) || (op == 3'b100);
    ea  = chain ? last_res : a;
    ey  = rsv ? 8'h00 : lu_model(1'b0, op, ea, b);
    if (push) begin
      sb_q.push_back({rsv, ey});
      last_res = ey;
    end
    cmd_op_in = op; cmd_a_in = a; cmd_b_in = b; cmd_chain_in = chain;
    cmd_valid_in = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
    check("issue_en", lu_en_out, rsv);
    check("issue_s", lu_s_out, op);
    check("issue_a", lu_a_out, ea);
    check("issue_b", lu_b_out, b);
    check("issue_ready", cmd_ready_out, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !cmd_ready_out) && n < 50) begin
      @(posedge clk_in); #1; n++;
    end
    check("drain_timeout", n < 50, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  held_y;
    logic [15:0] held_cnt;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", cmd_ready_out, 1);
    check("rst_valid", res_valid_out, 0);
    check("rst_en", lu_en_out, 1);
    check("rst_y", res_y_out, 0);
    check("rst_cnt", ops_count_out, 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // NAND F0,3C -> CF, then chain XOR/AND
    send(3'b000, 8'hF0, 8'h3C, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    check("nand_valid_t2", res_valid_out, 1);
    drain();
    send(3'b010, 8'hA5, 8'hFF, 1'b0, 1'b1);
    drain();
    send(3'b101, 8'h77, 8'h0F, 1'b1, 1'b1);
    drain();
    check("chain_result", res_y_out, 8'h0A);

    // Reserved opcode: enable never asserted, zero result, error flag
    send(3'b011, 8'hFF, 8'hFF, 1'b0, 1'b1);
    drain();
    send(3'b100, 8'h12, 8'h34, 1'b0, 1'b1);
    drain();
    send(3'b001, 8'h0F, 8'hF0, 1'b0, 1'b1);
    drain();
    check("nor_err_cleared", res_err_out, 0);

    // Backpressure in HOLD
    res_ready_in = 1'b0;
    send(3'b110, 8'h0C, 8'h30, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    held_y   = res_y_out;
    held_cnt = ops_count_out;
    check("bp_y", held_y, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid_out, 1);
      check("bp_y_stable", res_y_out, held_y);
      check("bp_ready", cmd_ready_out, 0);
      check("bp_cnt", ops_count_out, held_cnt);
      @(posedge clk_in); #1;
    end
    res_ready_in = 1'b1;
    @(posedge clk_in); #1;
    check("bp_release_cnt", ops_count_out, held_cnt + 16'd1);
    check("bp_release_ready", cmd_ready_out, 1);
    check("bp_release_valid", res_valid_out, 0);

    // Reset during ISSUE drops the command
    send(3'b110, 8'h12, 8'h34, 1'b0, 1'b0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("mid_rst_ready", cmd_ready_out, 1);
    check("mid_rst_valid", res_valid_out, 0);
    check("mid_rst_err", res_err_out, 0);
    check("mid_rst_y", res_y_out, 0);
    check("mid_rst_cnt", ops_count_out, 0);
    check("mid_rst_en", lu_en_out, 1);
    check("mid_rst_a", lu_a_out, 0);
    check("mid_rst_b", lu_b_out, 0);
    check("mid_rst_s", lu_s_out, 0);
    rst_in   = 1'b0;
    last_res = 8'h00;
    exp_cnt  = 0;
    @(posedge clk_in); #1;
    send(3'b101, 8'hEE, 8'hFF, 1'b1, 1'b1);
    drain();
    check("post_rst_chain", res_y_out, 8'h00);
    check("post_rst_cnt", ops_count_out, 1);

    // Narrow instance: NOT(0)=1, and 2-bit counter wraps after four ops
    for (int k = 0; k < 4; k++) begin
      op2 = (k == 0) ? 3'b111 : 3'b110;
      a2  = 1'b0;
      b2  = (k % 2 == 1) ? 1'b1 : 1'b0;
      v2  = 1'b1;
      @(posedge clk_in); #1;
      v2  = 1'b0;
      @(posedge clk_in); #1;
      check("n_valid", val2, 1);
      check("n_y", y2, (k == 0) ? 1 : b2);
      @(posedge clk_in); #1;
      check("n_cnt", cnt2, (k + 1) % 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_logic_sequencer
`default_nettype wire
